// File: rtl/safe_lockout_ctrl.sv
// Button-operated safe controller: press detection, three-digit entry checking,
// wrong-entry lockout with a timer, and passcode reprogramming while unlocked.
module safe_lockout_ctrl #(
    parameter int         MAX_ERR     = 3,
    parameter int         LOCK_CYCLES = 1000,
    parameter logic [3:0] CODE0       = 4'b0111,
    parameter logic [3:0] CODE1       = 4'b1101,
    parameter logic [3:0] CODE2       = 4'b1101
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     btn,
    input  logic                           relock,
    input  logic                           prog,
    output logic                           unlocked,
    output logic                           lockout,
    output logic                           prog_mode,
    output logic [1:0]                     digit_idx,
    output logic [$clog2(MAX_ERR+1)-1:0]   err_cnt
);

    localparam int EW = $clog2(MAX_ERR + 1);
    localparam int TW = $clog2(LOCK_CYCLES);

    localparam logic [3:0] S_IDLE     = 4'b0001;
    localparam logic [3:0] S_UNLOCKED = 4'b0010;
    localparam logic [3:0] S_PROG     = 4'b0100;
    localparam logic [3:0] S_LOCKOUT  = 4'b1000;

    localparam logic [EW-1:0] ERR_MAX  = EW'(MAX_ERR);
    localparam logic [EW-1:0] ERR_LAST = EW'(MAX_ERR - 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(LOCK_CYCLES - 1);

    logic [3:0]    r_state;
    logic [3:0]    r_btn_q;
    logic [1:0]    r_digit_idx;
    logic [EW-1:0] r_err_cnt;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_code0, r_code1, r_code2;
    logic [3:0]    r_entry0, r_entry1;
    logic [3:0]    r_new0, r_new1;

    logic w_press;
    logic w_match;

    assign w_press = (btn != 4'd0) && (r_btn_q == 4'd0);
    assign w_match = ({r_entry0, r_entry1, btn} == {r_code0, r_code1, r_code2});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q <= 4'd0;
        end else begin
            r_btn_q <= btn;
        end
    end

    // Main sequencer; relock beats prog beats a press wherever they compete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_digit_idx <= 2'd0;
            r_err_cnt   <= '0;
            r_timer     <= '0;
            r_code0     <= CODE0;
            r_code1     <= CODE1;
            r_code2     <= CODE2;
            r_entry0    <= 4'd0;
            r_entry1    <= 4'd0;
            r_new0      <= 4'd0;
            r_new1      <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        if (r_digit_idx == 2'd0) begin
                            r_entry0    <= btn;
                            r_digit_idx <= 2'd1;
                        end else if (r_digit_idx == 2'd1) begin
                            r_entry1    <= btn;
                            r_digit_idx <= 2'd2;
                        end else begin
                            r_digit_idx <= 2'd0;
                            if (w_match) begin
                                r_state   <= S_UNLOCKED;
                                r_err_cnt <= '0;
                            end else if (r_err_cnt == ERR_LAST) begin
                                r_state   <= S_LOCKOUT;
                                r_err_cnt <= ERR_MAX;
                                r_timer   <= TMR_LOAD;
                            end else begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state     <= S_IDLE;
                        r_err_cnt   <= '0;
                        r_digit_idx <= 2'd0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_UNLOCKED: begin
                    if (relock) begin
                        r_state     <= S_IDLE;
                        r_digit_idx <= 2'd0;
                    end else if (prog) begin
                        r_state     <= S_PROG;
                        r_digit_idx <= 2'd0;
                    end
                end
                S_PROG: begin
                    if (relock) begin
                        r_state     <= S_IDLE;
                        r_digit_idx <= 2'd0;
                        r_new0      <= 4'd0;
                        r_new1      <= 4'd0;
                    end else if (w_press) begin
                        if (r_digit_idx == 2'd0) begin
                            r_new0      <= btn;
                            r_digit_idx <= 2'd1;
                        end else if (r_digit_idx == 2'd1) begin
                            r_new1      <= btn;
                            r_digit_idx <= 2'd2;
                        end else begin
                            r_code0     <= r_new0;
                            r_code1     <= r_new1;
                            r_code2     <= btn;
                            r_digit_idx <= 2'd0;
                            r_state     <= S_UNLOCKED;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_digit_idx <= 2'd0;
                end
            endcase
        end
    end

    assign unlocked  = r_state[1] | r_state[2];
    assign prog_mode = r_state[2];
    assign lockout   = r_state[3];
    assign digit_idx = r_digit_idx;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// Self-checking bench for safe_lockout_ctrl: directed scenarios plus a long
// randomized run, all compared against a queue-based behavioural model.
module tb_safe_lockout_ctrl;

    localparam int MAX_ERR     = 3;
    localparam int LOCK_CYCLES = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'd0;
    logic       relock = 1'b0;
    logic       prog = 1'b0;
    logic       unlocked, lockout, prog_mode;
    logic [1:0] digit_idx;
    logic [1:0] err_cnt;

    int errors = 0;
    int checks = 0;

    safe_lockout_ctrl #(
        .MAX_ERR    (MAX_ERR),
        .LOCK_CYCLES(LOCK_CYCLES),
        .CODE0      (4'h7),
        .CODE1      (4'hD),
        .CODE2      (4'hD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .relock   (relock),
        .prog     (prog),
        .unlocked (unlocked),
        .lockout  (lockout),
        .prog_mode(prog_mode),
        .digit_idx(digit_idx),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    logic [6:0] dutVec;
    assign dutVec = {unlocked, lockout, prog_mode, digit_idx, err_cnt};

    // Behavioural model: a mode, the digits typed so far, and a lockout countdown.
    typedef enum {M_IDLE, M_OPEN, M_PROG, M_LOCK} mode_t;
    mode_t      mMode;
    logic [3:0] mCode[3];
    logic [3:0] mDigits[$];
    int         mErr;
    int         mLockLeft;
    logic [3:0] mPrevBtn;

    function automatic void modelReset();
        mMode = M_IDLE;
        mCode[0] = 4'h7; mCode[1] = 4'hD; mCode[2] = 4'hD;
        mDigits.delete();
        mErr = 0;
        mLockLeft = 0;
        mPrevBtn = 4'd0;
    endfunction

    function automatic void modelStep(logic [3:0] b, logic rl, logic pg);
        bit press;
        bit same;
        press = (b != 4'd0) && (mPrevBtn == 4'd0);
        mPrevBtn = b;
        case (mMode)
            M_IDLE: if (press) begin
                mDigits.push_back(b);
                if (mDigits.size() == 3) begin
                    same = 1;
                    for (int i = 0; i < 3; i++) if (mDigits[i] != mCode[i]) same = 0;
                    mDigits.delete();
                    if (same) begin
                        mMode = M_OPEN;
                        mErr = 0;
                    end else begin
                        mErr++;
                        if (mErr >= MAX_ERR) begin
                            mErr = MAX_ERR;
                            mMode = M_LOCK;
                            mLockLeft = LOCK_CYCLES;
                        end
                    end
                end
            end
            M_LOCK: begin
                mLockLeft--;
                if (mLockLeft == 0) begin
                    mMode = M_IDLE;
                    mErr = 0;
                    mDigits.delete();
                end
            end
            M_OPEN: begin
                if (rl) begin
                    mMode = M_IDLE;
                    mDigits.delete();
                end else if (pg) begin
                    mMode = M_PROG;
                    mDigits.delete();
                end
            end
            M_PROG: begin
                if (rl) begin
                    mMode = M_IDLE;
                    mDigits.delete();
                end else if (press) begin
                    mDigits.push_back(b);
                    if (mDigits.size() == 3) begin
                        for (int i = 0; i < 3; i++) mCode[i] = mDigits[i];
                        mDigits.delete();
                        mMode = M_OPEN;
                    end
                end
            end
            default: mMode = M_IDLE;
        endcase
    endfunction

    function automatic logic [6:0] expVec();
        return {(mMode == M_OPEN) || (mMode == M_PROG), mMode == M_LOCK, mMode == M_PROG,
                2'(mDigits.size()), 2'(mErr)};
    endfunction

    // Drives one cycle of inputs, advances the model on the edge, samples 1ns later.
    task automatic applyStimulus(input logic [3:0] b, input logic rl, input logic pg);
        btn = b;
        relock = rl;
        prog = pg;
        @(posedge clk);
        modelStep(b, rl, pg);
        #1;
    endtask

    task automatic pressDigit(input logic [3:0] d);
        applyStimulus(d, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0);
    endtask

    task automatic enterCode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        pressDigit(a);
        pressDigit(b);
        pressDigit(c);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        btn = 4'd0; relock = 1'b0; prog = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (dutVec !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected %b", dutVec, 7'd0);
        end
    endtask

    task automatic test_unlock();
        enterCode(4'h7, 4'hD, 4'hD);
        checks++;
        if (unlocked !== 1'b1 || err_cnt !== 2'd0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL unlock_default: got %b expected %b", dutVec, expVec());
        end
        applyStimulus(4'd0, 1'b1, 1'b0);
        checks++;
        if (unlocked !== 1'b0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL relock: got %b expected %b", dutVec, expVec());
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) applyStimulus(4'h7, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0);
        checks++;
        if (digit_idx !== 2'd1 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL hold_one_digit: got %b expected %b", dutVec, expVec());
        end
        doReset();
    endtask

    task automatic test_lockout();
        int n;
        int guard;
        enterCode(4'h1, 4'h2, 4'h3);
        checks++;
        if (err_cnt !== 2'd1 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL err_step1: got %b expected %b", dutVec, expVec());
        end
        enterCode(4'h1, 4'h2, 4'h3);
        checks++;
        if (err_cnt !== 2'd2 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL err_step2: got %b expected %b", dutVec, expVec());
        end
        pressDigit(4'h1);
        pressDigit(4'h2);
        applyStimulus(4'h3, 1'b0, 1'b0);
        checks++;
        if (lockout !== 1'b1 || err_cnt !== 2'd3 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL lockout_enter: got %b expected %b", dutVec, expVec());
        end
        n = 1;
        guard = 0;
        while (lockout === 1'b1 && guard < LOCK_CYCLES + 10) begin
            applyStimulus((guard % 2 == 0) ? 4'd0 : 4'($urandom_range(1, 15)), 1'b0, 1'b0);
            guard++;
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL lockout_cycle%0d: got %b expected %b", guard, dutVec, expVec());
            end
            if (lockout === 1'b1) n++;
        end
        checks++;
        if (n != LOCK_CYCLES || lockout !== 1'b0 || err_cnt !== 2'd0 || digit_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lockout_length: got %0d cycles expected %0d", n, LOCK_CYCLES);
        end
        applyStimulus(4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_recover();
        enterCode(4'h1, 4'h2, 4'h3);
        enterCode(4'h4, 4'h5, 4'h6);
        enterCode(4'h7, 4'hD, 4'hD);
        checks++;
        if (unlocked !== 1'b1 || err_cnt !== 2'd0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL recover_unlock: got %b expected %b", dutVec, expVec());
        end
    endtask

    task automatic test_prog();
        applyStimulus(4'd0, 1'b0, 1'b1);
        checks++;
        if (prog_mode !== 1'b1 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL prog_enter: got %b expected %b", dutVec, expVec());
        end
        prog = 1'b0;
        enterCode(4'h1, 4'h2, 4'h3);
        checks++;
        if (unlocked !== 1'b1 || prog_mode !== 1'b0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL prog_done: got %b expected %b", dutVec, expVec());
        end
        applyStimulus(4'd0, 1'b1, 1'b0);
        enterCode(4'h7, 4'hD, 4'hD);
        checks++;
        if (unlocked !== 1'b0 || err_cnt !== 2'd1 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL old_code_rejected: got %b expected %b", dutVec, expVec());
        end
        enterCode(4'h1, 4'h2, 4'h3);
        checks++;
        if (unlocked !== 1'b1 || err_cnt !== 2'd0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL new_code_unlock: got %b expected %b", dutVec, expVec());
        end
    endtask

    task automatic test_reset_mid_prog();
        applyStimulus(4'd0, 1'b0, 1'b1);
        pressDigit(4'h9);
        pressDigit(4'hA);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if (dutVec !== 7'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_prog: got %b expected %b", dutVec, 7'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prog = 1'b0;
        enterCode(4'h7, 4'hD, 4'hD);
        checks++;
        if (unlocked !== 1'b1 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL code_reverted: got %b expected %b", dutVec, expVec());
        end
    endtask

    task automatic test_relock_and_prog();
        applyStimulus(4'd0, 1'b1, 1'b1);
        checks++;
        if (unlocked !== 1'b0 || prog_mode !== 1'b0 || dutVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL relock_beats_prog: got %b expected %b", dutVec, expVec());
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        logic rl, pg;
        int localErr;
        b = 4'd0;
        localErr = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    b = 4'd0;
                    2:       b = mCode[0];
                    3:       b = mCode[1];
                    4:       b = mCode[2];
                    default: b = 4'($urandom_range(1, 15));
                endcase
            end
            rl = ($urandom_range(0, 59) == 0);
            pg = ($urandom_range(0, 7) == 0);
            applyStimulus(b, rl, pg);
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                localErr++;
                if (localErr <= 10)
                    $display("[TB] FAIL random_cycle%0d: got %b expected %b", i, dutVec, expVec());
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_unlock();
        test_hold();
        test_lockout();
        test_recover();
        test_prog();
        test_reset_mid_prog();
        test_relock_and_prog();
        doReset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
